signext_unit: RTL and testbench

- Immediate sign-extension unit for the LEGv8 single-cycle datapath.
- Decodes the opcode field of a 32-bit instruction word and extracts that format's immediate field.
- Sign-extends the immediate to 64 bits for the ALU and branch-target path.
- Provides a combinational result and a registered copy with a validity flag for pipelined or debug consumers.

---
 rtl/signext_pkg.sv | 36 +++
 rtl/signext_decode.sv | 26 ++
 rtl/signext_unit.sv | 67 ++++++
 tb/tb_signext_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/signext_pkg.sv
// Shared opcode constants, immediate format enum and field positions for the
// LEGv8 immediate sign-extension unit.
package signext_pkg;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_D,
    FMT_CB,
    FMT_I,
    FMT_B
  } imm_fmt_e;

  localparam int D_MSB  = 20;
  localparam int D_LSB  = 12;
  localparam int CB_MSB = 23;
  localparam int CB_LSB = 5;
  localparam int I_MSB  = 21;
  localparam int I_LSB  = 10;
  localparam int B_MSB  = 25;
  localparam int B_LSB  = 0;

  localparam int D_W  = D_MSB - D_LSB + 1;
  localparam int CB_W = CB_MSB - CB_LSB + 1;
  localparam int I_W  = I_MSB - I_LSB + 1;
  localparam int B_W  = B_MSB - B_LSB + 1;

endpackage

// File: rtl/signext_decode.sv
// Opcode classifier: maps instruction bits [31:21] to an immediate format.
// SIGNEXT_EXT_FMT_EN adds the I- and B-formats below CB in priority.
module signext_decode
  import signext_pkg::*;
(
  input  logic [10:0] op,
  output imm_fmt_e    fmt
);

  always_comb begin
    if (op == OP_LDUR || op == OP_STUR) begin
      fmt = FMT_D;
    end else if (op[10:3] == OP_CBZ || op[10:3] == OP_CBNZ) begin
      fmt = FMT_CB;
`ifdef SIGNEXT_EXT_FMT_EN
    end else if (op[10:1] == OP_ADDI || op[10:1] == OP_SUBI) begin
      fmt = FMT_I;
    end else if (op[10:5] == OP_B || op[10:5] == OP_BL) begin
      fmt = FMT_B;
`endif
    end else begin
      fmt = FMT_NONE;
    end
  end

endmodule

// File: rtl/signext_unit.sv
// LEGv8 immediate extraction and sign-extension with a registered copy.
// Optional I/B formats are enabled by defining SIGNEXT_EXT_FMT_EN.
module signext_unit
  import signext_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] a,
  output logic [DATA_W-1:0]  y,
  output logic               hit,
  output logic [DATA_W-1:0]  y_q,
  output logic               hit_q
);

  imm_fmt_e fmt;

  signext_decode u_decode (
    .op  (a[31:21]),
    .fmt (fmt)
  );

`ifndef SIGNEXT_EXT_FMT_EN
  // Low bits carry register numbers only; no enabled format reads them.
  logic unused_low_bits;
  assign unused_low_bits = ^a[4:0];
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns y/hit and no latch is inferred.
    y   = '0;
    hit = 1'b0;
    case (fmt)
      FMT_D: begin
        y   = {{(DATA_W-D_W){a[D_MSB]}}, a[D_MSB:D_LSB]};
        hit = 1'b1;
      end
      FMT_CB: begin
        y   = {{(DATA_W-CB_W){a[CB_MSB]}}, a[CB_MSB:CB_LSB]};
        hit = 1'b1;
      end
      FMT_I: begin
        y   = {{(DATA_W-I_W){1'b0}}, a[I_MSB:I_LSB]};
        hit = 1'b1;
      end
      FMT_B: begin
        y   = {{(DATA_W-B_W){a[B_MSB]}}, a[B_MSB:B_LSB]};
        hit = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      hit_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so the register samples the pre-edge combinational value.
      y_q   <= y;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_signext_unit.sv
// Self-checking bench for signext_unit: directed plan vectors, boundary cases,
// async reset behaviour and randomized words against an arithmetic model.
module tb_signext_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [63:0] y, y_q;
  logic        hit, hit_q;

  int total = 0;
  int bad   = 0;

  signext_unit #(.DATA_W(64), .INSTR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .y     (y),
    .hit   (hit),
    .y_q   (y_q),
    .hit_q (hit_q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: field value as an integer, shifted into the negative
  // range when its top bit is set, then cast to 64 bits.
  function automatic void ref_model(input logic [31:0] w, output logic [63:0] ey, output logic eh);
    longint v;
    longint unsigned u;
    u  = longint'(w);
    ey = 64'd0;
    eh = 1'b0;
    if ((u >> 21) == 64'h7C2 || (u >> 21) == 64'h7C0) begin
      v = longint'((u >> 12) % 512);
      if (v >= 256) v = v - 512;
      ey = 64'(v);
      eh = 1'b1;
    end else if ((u >> 24) == 64'hB4 || (u >> 24) == 64'hB5) begin
      v = longint'((u >> 5) % (1 << 19));
      if (v >= (1 << 18)) v = v - (1 << 19);
      ey = 64'(v);
      eh = 1'b1;
`ifdef SIGNEXT_EXT_FMT_EN
    end else if ((u >> 22) == 64'h244 || (u >> 22) == 64'h344) begin
      ey = (u >> 10) % 4096;
      eh = 1'b1;
    end else if ((u >> 26) == 64'h05 || (u >> 26) == 64'h25) begin
      v = longint'(u % (1 << 26));
      if (v >= (1 << 25)) v = v - (1 << 26);
      ey = 64'(v);
      eh = 1'b1;
`endif
    end
  endfunction

  // Drive a word, check the combinational outputs, then the registered copy.
  task automatic apply(input string tag, input logic [31:0] w,
                       input logic [63:0] exp_y, input logic exp_hit);
    @(negedge clk);
    a = w;
    #1;
    check({tag, ".y"}, y, exp_y);
    check({tag, ".hit"}, 64'(hit), 64'(exp_hit));
    @(posedge clk);
    #1;
    check({tag, ".y_q"}, y_q, exp_y);
    check({tag, ".hit_q"}, 64'(hit_q), 64'(exp_hit));
  endtask

  initial begin
    logic [63:0] ey;
    logic        eh;
    logic [31:0] w;
    logic [63:0] ext_i_y, ext_b_y;
    logic        ext_hit;

    rst_n = 1'b0;
    a     = {11'b11111000010, 9'd16, 2'b00, 5'd5, 5'd6};
    repeat (2) @(posedge clk);
    #1;
    check("reset.y_q", y_q, 64'd0);
    check("reset.hit_q", 64'(hit_q), 64'd0);
    check("reset.y_comb", y, 64'd16);
    @(negedge clk);
    rst_n = 1'b1;

    apply("ldur16", {11'b11111000010, 9'd16, 2'b00, 5'd5, 5'd6}, 64'd16, 1'b1);
    apply("stur124", {11'b11111000000, 9'd124, 2'b00, 5'd5, 5'd6}, 64'd124, 1'b1);
    apply("stur192", {11'b11111000000, 9'd192, 2'b00, 5'd5, 5'd6}, 64'd192, 1'b1);
    apply("zero", 32'd0, 64'd0, 1'b0);
    apply("stur_neg16", {11'b11111000000, 9'h1F0, 2'b00, 5'd5, 5'd6}, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
    apply("imm9_100", {11'b11111000010, 9'h100, 2'b00, 5'd0, 5'd0}, 64'hFFFF_FFFF_FFFF_FF00, 1'b1);
    apply("imm9_0ff", {11'b11111000010, 9'h0FF, 2'b00, 5'd0, 5'd0}, 64'h0000_0000_0000_00FF, 1'b1);
    apply("cbz_ones", {8'b10110100, 19'h7FFFF, 5'd0}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    apply("cbnz100", {8'b10110101, 19'd100, 5'd3}, 64'd100, 1'b1);

`ifdef SIGNEXT_EXT_FMT_EN
    ext_i_y = 64'd4095;
    ext_b_y = 64'hFFFF_FFFF_FFFF_FFFF;
    ext_hit = 1'b1;
`else
    ext_i_y = 64'd0;
    ext_b_y = 64'd0;
    ext_hit = 1'b0;
`endif
    apply("addi_fff", {10'b1001000100, 12'hFFF, 5'd5, 5'd6}, ext_i_y, ext_hit);
    apply("b_ones", {6'b000101, 26'h3FFFFFF}, ext_b_y, ext_hit);

    // Mid-cycle async reset while hit_q is set.
    apply("pre_rst", {11'b11111000010, 9'd16, 2'b00, 5'd5, 5'd6}, 64'd16, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.y_q", y_q, 64'd0);
    check("async_rst.hit_q", 64'(hit_q), 64'd0);
    check("async_rst.y", y, 64'd16);
    a = {8'b10110101, 19'd100, 5'd3};
    #1;
    check("in_rst.y_tracks", y, 64'd100);
    check("in_rst.hit_tracks", 64'(hit), 64'd1);
    @(posedge clk);
    #1;
    check("in_rst.y_q_held", y_q, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.y_q_before_edge", y_q, 64'd0);
    @(posedge clk);
    #1;
    check("rel.y_q_capture", y_q, 64'd100);
    check("rel.hit_q_capture", 64'(hit_q), 64'd1);

    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      case ($urandom_range(0, 6))
        0: w[31:21] = 11'b11111000010;
        1: w[31:21] = 11'b11111000000;
        2: w[31:24] = 8'b10110100;
        3: w[31:24] = 8'b10110101;
        4: w[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
        5: w[31:26] = ($urandom_range(0, 1) != 0) ? 6'b000101 : 6'b100101;
        default: ;
      endcase
      ref_model(w, ey, eh);
      apply($sformatf("rand%0d", i), w, ey, eh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
